// File: rtl/rtn_xbar_gen.sv
// rtn_xbar_gen: per-bank response FIFOs routed to channels through round-robin arbiters.
// Define RTN_XBAR_OUT_REG_EN to insert a registered output stage on every channel.
module rtn_xbar_gen #(
  parameter int  NUM_BANKS    = 4,
  parameter int  NUM_CHANNELS = 3,
  parameter int  DATA_W       = 128,
  parameter int  DEPTH        = 8,
  parameter type robWidth_t   = logic,
  localparam int CH_W = ($clog2(NUM_CHANNELS) > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int BK_W = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_BANKS-1:0]                d_bank_rsp_valid,
  output logic [NUM_BANKS-1:0]                d_bank_rsp_ready,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]    d_bank_rsp_data,
  input  logic [NUM_BANKS-1:0][CH_W-1:0]      d_bank_rsp_channel_id,
  input  robWidth_t [NUM_BANKS-1:0]           d_bank_rsp_rob_id,
  output logic [NUM_CHANNELS-1:0]             u_channel_rsp_valid,
  input  logic [NUM_CHANNELS-1:0]             u_channel_rsp_ready,
  output logic [NUM_CHANNELS-1:0][DATA_W-1:0] u_channel_rsp_data,
  output logic [NUM_CHANNELS-1:0][BK_W-1:0]   u_channel_rsp_bank_id,
  output robWidth_t [NUM_CHANNELS-1:0]        u_channel_rsp_rob_id,
  output logic [NUM_BANKS-1:0]                bad_ch_err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0]       r_data [NUM_BANKS][DEPTH];
  logic [CH_W-1:0]         r_ch   [NUM_BANKS][DEPTH];
  robWidth_t               r_rob  [NUM_BANKS][DEPTH];
  logic [AW:0]             r_wp   [NUM_BANKS];
  logic [AW:0]             r_rp   [NUM_BANKS];
  logic [NUM_BANKS-1:0]    w_full, w_empty, w_push, w_pop, w_cpop, w_badhd, r_bad;
  logic [DATA_W-1:0]       w_hd_data [NUM_BANKS];
  logic [CH_W-1:0]         w_hd_ch   [NUM_BANKS];
  robWidth_t               w_hd_rob  [NUM_BANKS];
  logic [NUM_CHANNELS-1:0] w_avl, w_take;
  logic [BK_W-1:0]         w_rr  [NUM_CHANNELS];
  logic [BK_W-1:0]         w_gnt [NUM_CHANNELS];
  logic [BK_W-1:0]         w_nxt [NUM_CHANNELS];
  logic [BK_W-1:0]         r_ptr [NUM_CHANNELS];
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_full[b]           = (r_wp[b][AW-1:0] == r_rp[b][AW-1:0]) && (r_wp[b][AW] != r_rp[b][AW]);
      w_empty[b]          = r_wp[b] == r_rp[b];
      d_bank_rsp_ready[b] = rst_n && !w_full[b];
      w_push[b]           = d_bank_rsp_valid[b] && rst_n && !w_full[b];
      w_hd_data[b]        = r_data[b][r_rp[b][AW-1:0]];
      w_hd_ch[b]          = r_ch[b][r_rp[b][AW-1:0]];
      w_hd_rob[b]         = r_rob[b][r_rp[b][AW-1:0]];
      w_badhd[b]          = !w_empty[b] && (32'(w_hd_ch[b]) >= NUM_CHANNELS);
    end
  end
  // Round-robin scan: walk downward so the bank closest after r_ptr wins.
  always_comb begin
    logic [BK_W-1:0] w_ix;
    w_ix = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_avl[c] = 1'b0;
      w_rr[c]  = '0;
      for (int i = NUM_BANKS - 1; i >= 0; i--) begin
        w_ix = BK_W'((32'(r_ptr[c]) + i) % NUM_BANKS);
        if (!w_empty[w_ix] && (32'(w_hd_ch[w_ix]) == c)) begin
          w_avl[c] = 1'b1;
          w_rr[c]  = w_ix;
        end
      end
    end
  end
  always_comb begin
    w_cpop = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_nxt[c] = (32'(w_gnt[c]) == NUM_BANKS - 1) ? '0 : w_gnt[c] + 1'b1;
      if (w_take[c]) w_cpop[w_gnt[c]] = 1'b1;
    end
  end
  // A bad-channel head is flagged for one cycle, then dropped as that flag retires.
  assign w_pop      = w_cpop | r_bad;
  assign bad_ch_err = r_bad;
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_push[b]) begin
        r_data[b][r_wp[b][AW-1:0]] <= d_bank_rsp_data[b];
        r_ch[b][r_wp[b][AW-1:0]]   <= d_bank_rsp_channel_id[b];
        r_rob[b][r_wp[b][AW-1:0]]  <= d_bank_rsp_rob_id[b];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_wp[b] <= '0;
        r_rp[b] <= '0;
      end
      r_bad <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_wp[b] <= r_wp[b] + (AW+1)'(w_push[b]);
        r_rp[b] <= r_rp[b] + (AW+1)'(w_pop[b]);
      end
      r_bad <= w_badhd & ~r_bad;
    end
  end
`ifdef RTN_XBAR_OUT_REG_EN
  logic [NUM_CHANNELS-1:0]             r_ov;
  logic [NUM_CHANNELS-1:0][DATA_W-1:0] r_od;
  logic [NUM_CHANNELS-1:0][BK_W-1:0]   r_obk;
  robWidth_t [NUM_CHANNELS-1:0]        r_orob;
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_gnt[c]  = w_rr[c];
      w_take[c] = w_avl[c] && (!r_ov[c] || u_channel_rsp_ready[c]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov   <= '0;
      r_od   <= '0;
      r_obk  <= '0;
      r_orob <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_ptr[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (w_take[c]) begin
          r_ov[c]   <= 1'b1;
          r_od[c]   <= w_hd_data[w_gnt[c]];
          r_obk[c]  <= w_gnt[c];
          r_orob[c] <= w_hd_rob[w_gnt[c]];
          r_ptr[c]  <= w_nxt[c];
        end else if (u_channel_rsp_ready[c]) begin
          r_ov[c] <= 1'b0;
        end
      end
    end
  end
  assign u_channel_rsp_valid   = r_ov;
  assign u_channel_rsp_data    = r_od;
  assign u_channel_rsp_bank_id = r_obk;
  assign u_channel_rsp_rob_id  = r_orob;
`else
  logic [NUM_CHANNELS-1:0] r_lock;
  logic [BK_W-1:0]         r_lock_bk [NUM_CHANNELS];
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_gnt[c]                 = r_lock[c] ? r_lock_bk[c] : w_rr[c];
      u_channel_rsp_valid[c]   = r_lock[c] || w_avl[c];
      w_take[c]                = u_channel_rsp_valid[c] && u_channel_rsp_ready[c];
      u_channel_rsp_data[c]    = u_channel_rsp_valid[c] ? w_hd_data[w_gnt[c]] : '0;
      u_channel_rsp_bank_id[c] = u_channel_rsp_valid[c] ? w_gnt[c] : '0;
      u_channel_rsp_rob_id[c]  = u_channel_rsp_valid[c] ? w_hd_rob[w_gnt[c]] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_lock_bk[c] <= '0;
        r_ptr[c]     <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_lock[c]    <= u_channel_rsp_valid[c] && !u_channel_rsp_ready[c];
        r_lock_bk[c] <= w_gnt[c];
        if (w_take[c]) r_ptr[c] <= w_nxt[c];
      end
    end
  end
`endif
endmodule

// File: tb/tb_rtn_xbar_gen.sv
// tb_rtn_xbar_gen: directed scenarios plus a randomized run against a queue-based model.
module tb_rtn_xbar_gen;
  localparam int NB    = 4;
  localparam int NC    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CH_W  = 2;
  localparam int BK_W  = 2;
`ifdef RTN_XBAR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NPUSH = DEPTH + LAT - 1;
  typedef logic [3:0] rob_t;
  typedef struct { logic [DW-1:0] d; int ch; rob_t r; } ent_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NB-1:0]           bv, brdy, err;
  logic [NB-1:0][DW-1:0]   bdata;
  logic [NB-1:0][CH_W-1:0] bch;
  rob_t [NB-1:0]           brob;
  logic [NC-1:0]           cv, crdy;
  logic [NC-1:0][DW-1:0]   cdata;
  logic [NC-1:0][BK_W-1:0] cbk;
  rob_t [NC-1:0]           crob;
  int n_tests = 0;
  int n_fail  = 0;
  ent_t mq [NB][$];
  int   mptr [NC];
  bit   mlk  [NC];
  int   mlkb [NC];

  rtn_xbar_gen #(.NUM_BANKS(NB), .NUM_CHANNELS(NC), .DATA_W(DW), .DEPTH(DEPTH), .robWidth_t(rob_t)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_bank_rsp_valid(bv), .d_bank_rsp_ready(brdy), .d_bank_rsp_data(bdata),
    .d_bank_rsp_channel_id(bch), .d_bank_rsp_rob_id(brob),
    .u_channel_rsp_valid(cv), .u_channel_rsp_ready(crdy), .u_channel_rsp_data(cdata),
    .u_channel_rsp_bank_id(cbk), .u_channel_rsp_rob_id(crob), .bad_ch_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    #1;
    n_tests++; if (cv !== '0 || cdata !== '0 || cbk !== '0 || crob !== '0) begin n_fail++; $display("FAIL reset_outputs: got v=%b bk=%h rob=%h want all zero", cv, cbk, crob); end
    n_tests++; if (err !== '0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (brdy !== '0) begin n_fail++; $display("FAIL reset_ready_low: got %b want 0000", brdy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (brdy !== 4'hF) begin n_fail++; $display("FAIL reset_ready_high: got %b want 1111", brdy); end
  endtask

  task automatic test_single();
    crdy = '0;
    @(negedge clk);
    bv = 4'b0100; bch[2] = 2'd1; bdata[2] = 32'hA5; brob[2] = 4'd5;
    @(negedge clk);
    bv = '0;
    repeat (LAT - 1) @(negedge clk);
    #1;
    n_tests++; if (cv !== 3'b010) begin n_fail++; $display("FAIL single_valid: got %b want 010", cv); end
    n_tests++; if (cdata[1] !== 32'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", cdata[1]); end
    n_tests++; if (cbk[1] !== 2'd2) begin n_fail++; $display("FAIL single_bank: got %0d want 2", cbk[1]); end
    n_tests++; if (crob[1] !== 4'd5) begin n_fail++; $display("FAIL single_rob: got %0d want 5", crob[1]); end
    crdy = '1;
    @(negedge clk);
    #1;
    n_tests++; if (cv !== '0) begin n_fail++; $display("FAIL single_drained: got %b want 000", cv); end
  endtask

  task automatic test_rr();
    int seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [DW-1:0] ed;
    crdy = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bv = 4'b1011;
      for (int b = 0; b < NB; b++) begin bch[b] = '0; bdata[b] = 32'(32'h100 * b + k); end
    end
    @(negedge clk);
    bv = '0;
    repeat (LAT) @(negedge clk);
    crdy = 3'b001;
    for (int k = 0; k < 6; k++) begin
      #1;
      ed = 32'(32'h100 * seq[k] + k / 3);
      n_tests++; if ({cv[0], cbk[0], cdata[0]} !== {1'b1, BK_W'(seq[k]), ed}) begin n_fail++; $display("FAIL rr_order[%0d]: got v=%b bk=%0d d=%h want v=1 bk=%0d d=%h", k, cv[0], cbk[0], cdata[0], seq[k], ed); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (cv[0] !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got %b want 0", cv[0]); end
  endtask

  task automatic test_full();
    int cnt = 0;
    crdy = 3'b011;
    for (int k = 0; k < NPUSH; k++) begin
      @(negedge clk);
      bv = 4'b0001; bch[0] = 2'd2; bdata[0] = 32'(32'h200 + k);
      #1;
      n_tests++; if (brdy[0] !== 1'b1) begin n_fail++; $display("FAIL full_ready_push%0d: got %b want 1", k, brdy[0]); end
    end
    @(negedge clk);
    bdata[0] = 32'hDEAD;
    #1;
    n_tests++; if (brdy[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b want 0", brdy[0]); end
    @(negedge clk);
    bv = '0; crdy = 3'b111;
    @(negedge clk);
    crdy = 3'b011;
    #1;
    n_tests++; if (brdy[0] !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b want 1", brdy[0]); end
    n_tests++; if ({cv[2], cdata[2]} !== {1'b1, 32'h201}) begin n_fail++; $display("FAIL full_one_pop: got v=%b d=%h want v=1 d=201", cv[2], cdata[2]); end
    crdy = 3'b111;
    for (int i = 0; i < 20; i++) begin
      if (cv[2]) cnt++;
      @(negedge clk);
      #1;
    end
    n_tests++; if (cnt !== NPUSH - 1) begin n_fail++; $display("FAIL full_remaining: got %0d want %0d", cnt, NPUSH - 1); end
  endtask

  task automatic test_lock();
    crdy = '0;
    @(negedge clk);
    bv = 4'b0100; bch[2] = 2'd1; bdata[2] = 32'h21; brob[2] = 4'd2;
    @(negedge clk);
    bv = 4'b0010; bch[1] = 2'd1; bdata[1] = 32'h11; brob[1] = 4'd1;
    @(negedge clk);
    bv = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if ({cv[1], cbk[1], cdata[1]} !== {1'b1, 2'd2, 32'h21}) begin n_fail++; $display("FAIL lock_hold[%0d]: got v=%b bk=%0d d=%h want v=1 bk=2 d=21", k, cv[1], cbk[1], cdata[1]); end
      @(negedge clk);
    end
    crdy = 3'b010;
    #1;
    n_tests++; if (cbk[1] !== 2'd2) begin n_fail++; $display("FAIL lock_at_hs: got %0d want 2", cbk[1]); end
    @(negedge clk);
    crdy = '0;
    #1;
    n_tests++; if ({cv[1], cbk[1], cdata[1], crob[1]} !== {1'b1, 2'd1, 32'h11, 4'd1}) begin n_fail++; $display("FAIL lock_next: got v=%b bk=%0d d=%h rob=%0d want v=1 bk=1 d=11 rob=1", cv[1], cbk[1], cdata[1], crob[1]); end
    crdy = 3'b010;
    @(negedge clk);
    #1;
    n_tests++; if (cv !== '0) begin n_fail++; $display("FAIL lock_drained: got %b want 000", cv); end
  endtask

  task automatic test_bad_ch();
    int np = 0;
    int first = -1;
    crdy = '1;
    @(negedge clk);
    bv = 4'b1000; bch[3] = 2'd3; bdata[3] = 32'h33; brob[3] = 4'd3;
    @(negedge clk);
    bv = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (cv !== '0 || err[2:0] !== '0) begin n_fail++; $display("FAIL bad_quiet[%0d]: got v=%b err=%b want v=000 err[2:0]=000", i, cv, err); end
      if (err[3]) begin np++; if (first < 0) first = i; end
      @(negedge clk);
    end
    n_tests++; if (np !== 1) begin n_fail++; $display("FAIL bad_pulse_count: got %0d want 1", np); end
    n_tests++; if (first !== 1) begin n_fail++; $display("FAIL bad_pulse_cycle: got %0d want 1", first); end
    bv = 4'b1000; bch[3] = 2'd0; bdata[3] = 32'h3C; brob[3] = 4'hC;
    @(negedge clk);
    bv = '0;
    repeat (LAT - 1) @(negedge clk);
    #1;
    n_tests++; if ({cv[0], cbk[0], cdata[0], crob[0]} !== {1'b1, 2'd3, 32'h3C, 4'hC}) begin n_fail++; $display("FAIL bad_then_good: got v=%b bk=%0d d=%h rob=%h want v=1 bk=3 d=3c rob=c", cv[0], cbk[0], cdata[0], crob[0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    crdy = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bv = '1;
      for (int b = 0; b < NB; b++) begin bch[b] = CH_W'(b % NC); bdata[b] = $urandom; brob[b] = rob_t'(b + 1); end
    end
    @(negedge clk);
    bv = '0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (cv !== '0) begin n_fail++; $display("FAIL midrst_valid: got %b want 000", cv); end
    n_tests++; if (cdata !== '0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", cdata); end
    n_tests++; if (cbk !== '0 || crob !== '0) begin n_fail++; $display("FAIL midrst_ids: got bk=%h rob=%h want 0", cbk, crob); end
    n_tests++; if (err !== '0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err); end
    n_tests++; if (brdy !== '0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0000", brdy); end
    @(negedge clk);
    rst_n = 1'b1; crdy = '1;
    #1;
    n_tests++; if (brdy !== 4'hF) begin n_fail++; $display("FAIL midrst_ready_back: got %b want 1111", brdy); end
    for (int i = 0; i < 6; i++) begin
      if (cv !== '0) seen = 1'b1;
      @(negedge clk);
      #1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: got %b want 0", seen); end
  endtask

  task automatic test_random();
    logic [NB-1:0] er;
    logic [NC-1:0] ev;
    int   eb [NC];
    bit   pf [NB];
    int   bb;
    ent_t e;
    for (int c = 0; c < NC; c++) begin mptr[c] = 0; mlk[c] = 0; mlkb[c] = 0; end
    for (int b = 0; b < NB; b++) mq[b].delete();
    repeat (400) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        bv[b]    = 1'($urandom_range(0, 1));
        bch[b]   = CH_W'($urandom_range(0, NC - 1));
        bdata[b] = $urandom;
        brob[b]  = rob_t'($urandom_range(0, 15));
      end
      for (int c = 0; c < NC; c++) crdy[c] = ($urandom_range(0, 3) != 0);
      #1;
      for (int b = 0; b < NB; b++) er[b] = mq[b].size() < DEPTH;
      n_tests++; if (brdy !== er) begin n_fail++; $display("FAIL rand_ready: got %b want %b", brdy, er); end
      for (int c = 0; c < NC; c++) begin
        ev[c] = 1'b0; eb[c] = 0;
        if (mlk[c]) begin
          ev[c] = 1'b1; eb[c] = mlkb[c];
        end else begin
          for (int i = 0; i < NB; i++) begin
            bb = (mptr[c] + i) % NB;
            if (!ev[c] && mq[bb].size() > 0 && mq[bb][0].ch == c) begin ev[c] = 1'b1; eb[c] = bb; end
          end
        end
      end
      n_tests++; if (cv !== ev) begin n_fail++; $display("FAIL rand_valid: got %b want %b", cv, ev); end
      for (int c = 0; c < NC; c++) begin
        if (ev[c]) begin
          e = mq[eb[c]][0];
          n_tests++; if ({cbk[c], cdata[c], crob[c]} !== {BK_W'(eb[c]), e.d, e.r}) begin n_fail++; $display("FAIL rand_ch%0d: got bk=%0d d=%h rob=%h want bk=%0d d=%h rob=%h", c, cbk[c], cdata[c], crob[c], eb[c], e.d, e.r); end
        end
      end
      @(posedge clk);
      for (int b = 0; b < NB; b++) pf[b] = bv[b] && (mq[b].size() < DEPTH);
      for (int c = 0; c < NC; c++) begin
        if (ev[c]) begin
          if (crdy[c]) begin
            e = mq[eb[c]].pop_front();
            mptr[c] = (eb[c] + 1) % NB;
            mlk[c]  = 1'b0;
          end else begin
            mlk[c]  = 1'b1;
            mlkb[c] = eb[c];
          end
        end
      end
      for (int b = 0; b < NB; b++) if (pf[b]) mq[b].push_back('{d: bdata[b], ch: int'(bch[b]), r: brob[b]});
    end
  endtask

  initial begin
    rst_n = 1'b0; bv = '0; bdata = '0; bch = '0; brob = '0; crdy = '0;
    test_reset();
    test_single();
    test_rr();
    test_full();
    test_lock();
    test_bad_ch();
    test_reset_mid();
`ifndef RTN_XBAR_OUT_REG_EN
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rtn_xbar_gen.md
RTN_XBAR_GEN -- requirements
Module: rtn_xbar_gen

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of bank response inputs, range 2..16.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3: number of channel response outputs, range 2..16.
REQ-003 SHALL have parameter DATA_W, default 128: width of the response data.
REQ-004 SHALL have parameter DEPTH, default 8: entries per bank buffer, power of 2, at least 2.
REQ-005 SHALL have parameter type robWidth_t, default logic: type of the ROB identifier.
REQ-006 SHALL define CH_W = max(1, clog2(NUM_CHANNELS)) and BK_W = max(1, clog2(NUM_BANKS)).
REQ-007 SHALL have clk  input  1: single clock; all state updates on the rising edge.
REQ-008 SHALL have rst_n  input  1: reset, asynchronous assert, active-low.
REQ-009 SHALL have d_bank_rsp_valid  input  [NUM_BANKS]: bank response valid.
REQ-010 SHALL have d_bank_rsp_ready  output  [NUM_BANKS]: bank response ready.
REQ-011 SHALL have d_bank_rsp_data  input  [NUM_BANKS][DATA_W]: bank response data.
REQ-012 SHALL have d_bank_rsp_channel_id  input  [NUM_BANKS][CH_W]: destination channel of the response.
REQ-013 SHALL have d_bank_rsp_rob_id  input  [NUM_BANKS] robWidth_t: ROB identifier of the response.
REQ-014 SHALL have u_channel_rsp_valid  output  [NUM_CHANNELS]: channel response valid.
REQ-015 SHALL have u_channel_rsp_ready  input  [NUM_CHANNELS]: channel response ready.
REQ-016 SHALL have u_channel_rsp_data  output  [NUM_CHANNELS][DATA_W]: channel response data.
REQ-017 SHALL have u_channel_rsp_bank_id  output  [NUM_CHANNELS][BK_W]: source bank, binary-encoded.
REQ-018 SHALL have u_channel_rsp_rob_id  output  [NUM_CHANNELS] robWidth_t: ROB identifier.
REQ-019 SHALL have bad_ch_err  output  [NUM_BANKS]: one-cycle pulse when an entry addressed to a channel >= NUM_CHANNELS is discarded.

Function
REQ-020 SHALL give each bank a FIFO of DEPTH entries, each holding {data, channel_id, rob_id}.
- Read and write pointers are clog2(DEPTH)+1 bits wide; the extra bit is a wrap bit.
- full = (addresses equal) and (wrap bits differ).
- empty = pointers equal.
REQ-021 SHALL drive d_bank_rsp_ready[b] = !full[b] combinationally; a push occurs when valid and ready are both high; there is no bypass when the FIFO is full.
REQ-022 SHALL allow a push and a pop of the same FIFO in the same cycle, with occupancy unchanged.
REQ-023 SHALL let bank b request channel c when FIFO b is not empty and its head channel_id equals c.
- Only the head entry is eligible, so head-of-line blocking is accepted.
REQ-024 SHALL discard a head entry whose channel_id >= NUM_CHANNELS one cycle after it reaches the head, and pulse bad_ch_err[b] in that cycle.
REQ-025 SHALL arbitrate per channel with round-robin among requesting banks.
- Priority starts at the bank after the last granted bank.
- The priority pointer resets to 0, so bank 0 has highest priority first.
REQ-026 SHALL update a channel's round-robin pointer only on a completed channel handshake (valid and ready both high).
REQ-027 SHALL lock the grant while u_channel_rsp_valid[c] is high and ready is low; valid, data, bank_id and rob_id stay stable until the handshake.
REQ-028 SHALL pop the granted bank's FIFO head exactly on that channel's handshake; different channels may pop different banks in the same cycle.
REQ-029 SHALL provide full throughput: one transfer per channel per cycle when ready is held high and requests are available.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear:
- all FIFO pointers;
- all round-robin pointers to 0;
- all grant locks;
- u_channel_rsp_valid, u_channel_rsp_data, u_channel_rsp_bank_id and u_channel_rsp_rob_id to 0;
- bad_ch_err to 0.
REQ-031 SHALL hold d_bank_rsp_ready low during reset; after deassertion it is 1.
REQ-032 SHALL discard in-flight entries on reset mid-operation; no handshake completes in the reset cycle.
REQ-033 SHALL leave FIFO storage arrays unreset.

Configuration
REQ-034 With RTN_XBAR_OUT_REG_EN defined, the block SHALL add a registered output stage per channel.
- Bank push to u_channel_rsp_valid latency is 2 cycles.
- The output stage refills when empty or when popped in the same cycle, so throughput stays full.
- The FIFO pop happens on transfer into the output stage.
REQ-035 Without RTN_XBAR_OUT_REG_EN, channel outputs SHALL be driven combinationally from the granted FIFO head, with latency 1 cycle.

Verification
REQ-036 SHALL cover: single push to bank 2, channel 1, data 0xA5, rob 5 -> channel 1 valid after 1 cycle (2 with OUT_REG) with data 0xA5, bank_id 2, rob_id 5.
REQ-037 SHALL cover: banks 0, 1 and 3 each hold 2 entries for channel 0, ready held high -> bank_id sequence 0, 1, 3, 0, 1, 3.
REQ-038 SHALL cover: bank 0 pushes DEPTH entries to channel 2 while channel 2 ready is low -> d_bank_rsp_ready[0] = 0 after 8 pushes; ready high for 1 cycle -> exactly 1 entry popped and bank ready returns to 1.
REQ-039 SHALL cover: channel 1 stalled on a grant from bank 2 while bank 1 becomes eligible -> bank_id remains 2 until the handshake.
REQ-040 SHALL cover: push with channel_id 3 (NUM_CHANNELS = 3) -> no channel valid and a single bad_ch_err[b] pulse.
REQ-041 SHALL cover: rst_n asserted with FIFOs half full -> all outputs 0 asynchronously and no stale entries after release.
